mdu_iter: RTL and testbench
===========================

MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal 8..64, even).
REQ-002 SHALL have parameter OP_W, default 8, one-hot op width; bit order {mul, mulh, mulhsu, mulhu, div, divu, rem, remu}, MSB first.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port flush  input  1  abort in-flight operation.
REQ-006 SHALL have port in_valid  input  1  request valid.
REQ-007 SHALL have port in_ready  output  1  unit can accept.
REQ-008 SHALL have port op  input  OP_W  one-hot operation select.
REQ-009 SHALL have port src1  input  XLEN  rs1 operand / dividend.
REQ-010 SHALL have port src2  input  XLEN  rs2 operand / divisor.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port result  output  XLEN  registered result.

Function
REQ-014 SHALL implement FSM IDLE, MUL, DIV, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 SHALL accept on in_valid&in_ready at edge T, latching op/src1/src2; inputs ignored while not IDLE.
REQ-016 Mul ops: IDLE->MUL->DONE; out_valid first high in cycle T+2; mul = low XLEN of product; mulh/mulhsu/mulhu = high XLEN of 2*XLEN signed*signed / signed*unsigned / unsigned*unsigned product.
REQ-017 Div ops, divisor nonzero and no overflow: IDLE->DIV for exactly XLEN cycles (radix-2 restoring on magnitudes)->DONE; out_valid first high at T+XLEN+1.
REQ-018 Signed div/rem SHALL take quotient sign = sign(src1)^sign(src2), remainder sign = sign(src1); truncation toward zero.
REQ-019 Divisor zero SHALL skip iteration (IDLE->MUL-latency path, out_valid at T+2): div/divu -> all ones; rem/remu -> src1.
REQ-020 Signed overflow (src1 = most-negative, src2 = all ones) SHALL take T+2 path: div -> src1; rem -> 0.
REQ-021 op == 0 SHALL be accepted and return 0 at T+2; multi-hot op is illegal, result undefined, no hang.
REQ-022 DONE SHALL hold result and out_valid stable until out_valid&out_ready, then ->IDLE next cycle (no same-cycle re-accept).
REQ-023 flush SHALL force ->IDLE at next edge from any state, dropping result; flush has priority over in_valid and out_ready in the same cycle.
REQ-024 Iteration counter SHALL be $clog2(XLEN)+1 bits and must not wrap before reaching XLEN.

Reset
REQ-025 rst SHALL force state=IDLE, counter=0, result=0, out_valid=0, in_ready=1 after the edge.
REQ-026 rst mid-MUL/DIV/DONE SHALL discard the operation; no out_valid afterward until a new accept.
REQ-027 rst SHALL have priority over flush and all handshakes.

Structure
REQ-028 Package mdu_pkg SHALL hold op bit-index constants, OP_W, and state encoding typedef.
REQ-029 Sub-module mdu_div_step SHALL implement one combinational restoring-division step (partial remainder, quotient bit); FSM, sign fixup, multiplier stay in mdu_iter.

Verification
REQ-030 mul src1=0xFFFFFFFF, src2=0x00000002 -> result 0xFFFFFFFE; mulh -> 0xFFFFFFFF; mulhu -> 0x00000001; out_valid at T+2.
REQ-031 div src1=0xFFFFFFF9 (-7), src2=2 -> 0xFFFFFFFD, out_valid at T+33; rem same operands -> 0xFFFFFFFF.
REQ-032 divu src1=100, src2=0 -> 0xFFFFFFFF at T+2; remu -> 100.
REQ-033 div src1=0x80000000, src2=0xFFFFFFFF -> 0x80000000 at T+2; rem -> 0.
REQ-034 divu 1000/7 with out_ready=0 for 5 cycles after out_valid -> result 142 held stable, in_ready=0, accept only after release cycle.
REQ-035 flush at T+10 of a div, then rst at T+1 of a mul -> out_valid never asserted, in_ready=1 next cycle each time.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared constants for the iterative multiply/divide unit: one-hot op bit
// positions (MSB-first mul..remu) and the FSM state encoding.
package mdu_pkg;
  localparam int OP_W      = 8;
  localparam int OP_MUL    = 7;
  localparam int OP_MULH   = 6;
  localparam int OP_MULHSU = 5;
  localparam int OP_MULHU  = 4;
  localparam int OP_DIV    = 3;
  localparam int OP_DIVU   = 2;
  localparam int OP_REM    = 1;
  localparam int OP_REMU   = 0;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
endpackage

// File: rtl/mdu_div_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            msb_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);
  logic [XLEN:0] sh;
  logic [XLEN:0] diff;

  // rem_i < divisor keeps sh below 2*divisor, so the top bit of diff is a clean borrow
  assign sh    = {rem_i, msb_i};
  assign diff  = sh - {1'b0, dvs_i};
  assign q_o   = ~diff[XLEN];
  assign rem_o = q_o ? diff[XLEN-1:0] : sh[XLEN-1:0];
endmodule

// File: rtl/mdu_iter.sv
// Iterative RISC-V M-extension unit: single-cycle multiply, XLEN-cycle
// restoring divide, with short-cut paths for divide-by-zero and overflow.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = mdu_pkg::OP_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);
  localparam int              CW       = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST     = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q;
  logic [OP_W-1:0]   op_q;
  logic [XLEN-1:0]   a_q, b_q, result_q;
  logic [XLEN-1:0]   rem_q, dvd_q, dvs_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_q_q, neg_r_q, in_ready_q, out_valid_q;

  // accept-time decode
  logic            in_div, in_sgn, in_ovf, go_div;
  logic [XLEN-1:0] mag1_d, mag2_d;

  assign in_div = op[OP_DIV] | op[OP_DIVU] | op[OP_REM] | op[OP_REMU];
  assign in_sgn = op[OP_DIV] | op[OP_REM];
  assign in_ovf = in_sgn && (src1 == MOST_NEG) && (src2 == '1);
  assign go_div = in_div && (src2 != '0) && !in_ovf;
  assign mag1_d = (in_sgn && src1[XLEN-1]) ? -src1 : src1;
  assign mag2_d = (in_sgn && src2[XLEN-1]) ? -src2 : src2;

  // sign-extended operands make one unsigned multiplier serve all four variants
  logic            s1, s2;
  logic [2*XLEN-1:0] ma, mb, prod;
  logic [XLEN-1:0] short_res_d;

  assign s1   = op_q[OP_MULH] | op_q[OP_MULHSU];
  assign s2   = op_q[OP_MULH];
  assign ma   = {{XLEN{s1 & a_q[XLEN-1]}}, a_q};
  assign mb   = {{XLEN{s2 & b_q[XLEN-1]}}, b_q};
  assign prod = ma * mb;

  always_comb begin
    short_res_d = '0;
    if (op_q[OP_MUL])
      short_res_d = prod[XLEN-1:0];
    else if (op_q[OP_MULH] | op_q[OP_MULHSU] | op_q[OP_MULHU])
      short_res_d = prod[2*XLEN-1:XLEN];
    else if (op_q[OP_DIV] | op_q[OP_DIVU])
      short_res_d = (b_q == '0) ? '1 : a_q;
    else if (op_q[OP_REM] | op_q[OP_REMU])
      short_res_d = (b_q == '0) ? a_q : '0;
  end

  logic [XLEN-1:0] step_rem, q_fin, div_res_d;
  logic            step_q;

  mdu_div_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .msb_i (dvd_q[XLEN-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  assign q_fin     = {dvd_q[XLEN-2:0], step_q};
  assign div_res_d = (op_q[OP_REM] | op_q[OP_REMU])
                   ? (neg_r_q ? -step_rem : step_rem)
                   : (neg_q_q ? -q_fin : q_fin);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          op_q       <= op;
          a_q        <= src1;
          b_q        <= src2;
          in_ready_q <= 1'b0;
          cnt_q      <= '0;
          rem_q      <= '0;
          dvd_q      <= mag1_d;
          dvs_q      <= mag2_d;
          neg_q_q    <= in_sgn & (src1[XLEN-1] ^ src2[XLEN-1]);
          neg_r_q    <= in_sgn & src1[XLEN-1];
          state_q    <= go_div ? S_DIV : S_MUL;
        end
        S_MUL: begin
          result_q    <= short_res_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DIV: begin
          rem_q <= step_rem;
          dvd_q <= q_fin;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            result_q    <= div_res_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter (XLEN=32): vector table plus handshake,
// flush and reset corner sequences.
module tb_mdu_iter;
  localparam logic [7:0] MUL = 8'h80, MULH = 8'h40, MULHSU = 8'h20, MULHU = 8'h10;
  localparam logic [7:0] DIV = 8'h08, DIVU = 8'h04, REM = 8'h02, REMU = 8'h01;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  op;
  logic [31:0] src1, src2, result;

  int checks = 0;
  int failures = 0;

  mdu_iter #(.XLEN(32), .OP_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src1(src1), .src2(src2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [31:0] a, b, exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [7:0] o, logic [31:0] a, logic [31:0] b,
                              logic [31:0] e, int l);
    vec_t v;
    v.name = n; v.op = o; v.a = a; v.b = b; v.exp = e; v.lat = l;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Launch one op; lat counts edges after accept until out_valid is seen (T+lat).
  task automatic run_op(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res);
    op = o; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  int          lat;
  logic [31:0] res;
  logic        seen;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; src1 = '0; src2 = '0;

    vecs.push_back(mk("mul_neg1x2",    MUL,    32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE, 2));
    vecs.push_back(mk("mulh_neg1x2",   MULH,   32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 2));
    vecs.push_back(mk("mulhu_max_x2",  MULHU,  32'hFFFFFFFF, 32'h2,        32'h00000001, 2));
    vecs.push_back(mk("mulhsu_neg1",   MULHSU, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 2));
    vecs.push_back(mk("mulhsu_2xmax",  MULHSU, 32'h2,        32'hFFFFFFFF, 32'h00000001, 2));
    vecs.push_back(mk("mul_lo",        MUL,    32'h12345678, 32'h10,       32'h23456780, 2));
    vecs.push_back(mk("mulhu_hi",      MULHU,  32'h12345678, 32'h10,       32'h00000001, 2));
    vecs.push_back(mk("div_m7_2",      DIV,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 33));
    vecs.push_back(mk("rem_m7_2",      REM,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 33));
    vecs.push_back(mk("div_7_m2",      DIV,    32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33));
    vecs.push_back(mk("rem_7_m2",      REM,    32'h7,        32'hFFFFFFFE, 32'h00000001, 33));
    vecs.push_back(mk("divu_big_2",    DIVU,   32'hFFFFFFF9, 32'h2,        32'h7FFFFFFC, 33));
    vecs.push_back(mk("remu_big_2",    REMU,   32'hFFFFFFF9, 32'h2,        32'h00000001, 33));
    vecs.push_back(mk("div_minneg_2",  DIV,    32'h80000000, 32'h2,        32'hC0000000, 33));
    vecs.push_back(mk("divu_by0",      DIVU,   32'd100,      32'h0,        32'hFFFFFFFF, 2));
    vecs.push_back(mk("remu_by0",      REMU,   32'd100,      32'h0,        32'd100,      2));
    vecs.push_back(mk("div_by0",       DIV,    32'd5,        32'h0,        32'hFFFFFFFF, 2));
    vecs.push_back(mk("rem_by0",       REM,    32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 2));
    vecs.push_back(mk("div_ovf",       DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2));
    vecs.push_back(mk("rem_ovf",       REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2));
    vecs.push_back(mk("op_zero",       8'h00,  32'h1234,     32'h5678,     32'h00000000, 2));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, res);
      chk({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      chk({vecs[i].name, "_res"}, res, vecs[i].exp);
      @(posedge clk); #1;
      chk({vecs[i].name, "_release"}, {in_ready, out_valid}, 2'b10);
    end

    // backpressure: result held, new request ignored until after release
    out_ready = 1'b0;
    run_op(DIVU, 32'd1000, 32'd7, lat, res);
    chk("bp_lat", lat, 33);
    chk("bp_res", res, 32'd142);
    op = MUL; src1 = 32'd3; src2 = 32'd5; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_hold_res", result, 32'd142);
      chk("bp_hold_hs", {in_ready, out_valid}, 2'b01);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {in_ready, out_valid}, 2'b10);
    @(posedge clk); #1;
    chk("bp_accept", {in_ready, out_valid}, 2'b00);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_res", result, 32'd15);
    @(posedge clk); #1;

    // flush at T+10 of a divide
    op = DIV; src1 = 32'd1000; src2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_div_hs", {in_ready, out_valid}, 2'b10);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush_div_no_valid", seen, 0);

    // reset at T+1 of a multiply
    op = MUL; src1 = 32'd3; src2 = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mul_hs", {in_ready, out_valid}, 2'b10);
    chk("rst_mul_res", result, 0);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rst_mul_no_valid", seen, 0);

    // flush in DONE drops the held result
    out_ready = 1'b0;
    run_op(MUL, 32'd6, 32'd7, lat, res);
    chk("flush_done_res", res, 32'd42);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    out_ready = 1'b1;
    chk("flush_done_hs", {in_ready, out_valid}, 2'b10);

    // flush beats a same-cycle request in IDLE
    op = MUL; src1 = 32'd2; src2 = 32'd2; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_vs_req", {in_ready, out_valid}, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
